// File: rtl/alu_iter_divider.sv
`default_nettype none
// ============================================================================
//  Module      : alu_iter_divider
//  Description : Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU.
//                Produces one quotient bit per clock on operand magnitudes,
//                applies the sign in a final fix-up cycle and presents the
//                result over a valid/ready handshake. One op in flight.
//  Ports       : CLK, RST (sync, active-high), FLUSH (sync abort)
//                in_valid/in_ready, op_a (dividend), op_b (divisor),
//                op (00 DIV, 01 DIVU, 10 REM, 11 REMU)
//                out_valid/out_ready, result, busy
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_iter_divider #(
    parameter int BITWIDTH = 32
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                FLUSH,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [BITWIDTH-1:0] op_a,
    input  logic [BITWIDTH-1:0] op_b,
    input  logic [1:0]          op,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [BITWIDTH-1:0] result,
    output logic                busy
);

    localparam int                  c_cnt_w    = $clog2(BITWIDTH + 1);
    localparam logic [c_cnt_w-1:0]  c_cnt_init = c_cnt_w'(BITWIDTH);
    localparam logic [c_cnt_w-1:0]  c_cnt_one  = c_cnt_w'(1);
    localparam logic [BITWIDTH-1:0] c_min_neg  = {1'b1, {(BITWIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                state_q,     state_d;
    logic [c_cnt_w-1:0]    cnt_q,       cnt_d;
    logic [BITWIDTH-1:0]   rem_q,       rem_d;       // partial remainder
    logic [BITWIDTH-1:0]   quo_q,       quo_d;       // dividend shifts out, quotient shifts in
    logic [BITWIDTH-1:0]   dsr_q,       dsr_d;       // divisor magnitude
    logic                  is_rem_q,    is_rem_d;
    logic                  neg_quo_q,   neg_quo_d;
    logic                  neg_rem_q,   neg_rem_d;
    logic                  special_q,   special_d;   // quo_q already holds final result
    logic [BITWIDTH-1:0]   result_q,    result_d;
    logic                  out_valid_q, out_valid_d;

    // Operand decode on the accept path
    logic                w_signed, w_a_neg, w_b_neg, w_b_zero, w_ovf;
    logic [BITWIDTH-1:0] w_a_mag, w_b_mag, w_special_res;

    assign w_signed = ~op[0];
    assign w_a_neg  = w_signed & op_a[BITWIDTH-1];
    assign w_b_neg  = w_signed & op_b[BITWIDTH-1];
    assign w_a_mag  = w_a_neg ? -op_a : op_a;
    assign w_b_mag  = w_b_neg ? -op_b : op_b;
    assign w_b_zero = (op_b == '0);
    assign w_ovf    = w_signed && (op_a == c_min_neg) && (op_b == '1);

    always_comb begin
        w_special_res = '0;
        if (w_b_zero) begin
            w_special_res = op[1] ? op_a : '1;
        end else if (w_ovf) begin
            w_special_res = op[1] ? '0 : op_a;
        end
    end

    // One restoring step. The subtraction is one bit wider than the operands
    // so its MSB is the borrow that decides keep-vs-restore.
    logic [BITWIDTH:0]   w_rem_shift, w_diff;
    logic                w_step_ok;
    logic [BITWIDTH-1:0] w_quo_fix, w_rem_fix;

    assign w_rem_shift = {rem_q, quo_q[BITWIDTH-1]};
    assign w_diff      = w_rem_shift - {1'b0, dsr_q};
    assign w_step_ok   = ~w_diff[BITWIDTH];
    assign w_quo_fix   = neg_quo_q ? -quo_q : quo_q;
    assign w_rem_fix   = neg_rem_q ? -rem_q : rem_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dsr_d       = dsr_q;
        is_rem_d    = is_rem_q;
        neg_quo_d   = neg_quo_q;
        neg_rem_d   = neg_rem_q;
        special_d   = special_q;
        result_d    = result_q;
        out_valid_d = out_valid_q;

        if (FLUSH) begin
            // Abort wins over accept and handshake; result is kept as-is.
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
            cnt_d       = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        is_rem_d  = op[1];
                        neg_quo_d = w_a_neg ^ w_b_neg;
                        neg_rem_d = w_a_neg;
                        rem_d     = '0;
                        dsr_d     = w_b_mag;
                        cnt_d     = c_cnt_init;
                        if (w_b_zero || w_ovf) begin
                            special_d = 1'b1;
                            quo_d     = w_special_res;
                            state_d   = S_FIX;
                        end else begin
                            special_d = 1'b0;
                            quo_d     = w_a_mag;
                            state_d   = S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    rem_d = w_step_ok ? w_diff[BITWIDTH-1:0] : w_rem_shift[BITWIDTH-1:0];
                    quo_d = {quo_q[BITWIDTH-2:0], w_step_ok};
                    cnt_d = cnt_q - c_cnt_one;
                    if (cnt_q == c_cnt_one) begin
                        state_d = S_FIX;
                    end
                end
                S_FIX: begin
                    if (special_q) begin
                        result_d = quo_q;
                    end else if (is_rem_q) begin
                        result_d = w_rem_fix;
                    end else begin
                        result_d = w_quo_fix;
                    end
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_d = 1'b0;
                        state_d     = S_IDLE;
                    end
                end
                default: begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dsr_q       <= '0;
            is_rem_q    <= 1'b0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            special_q   <= 1'b0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dsr_q       <= dsr_d;
            is_rem_q    <= is_rem_d;
            neg_quo_q   <= neg_quo_d;
            neg_rem_q   <= neg_rem_d;
            special_q   <= special_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign out_valid = out_valid_q;
    assign result    = result_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_iter_divider.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_iter_divider
//  Description : Self-checking bench for alu_iter_divider (BITWIDTH = 32).
//                Directed vectors, special cases, backpressure, abort and
//                randomized ops against an arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_iter_divider;

    localparam int BW = 32;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          FLUSH = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [BW-1:0] op_a = '0;
    logic [BW-1:0] op_b = '0;
    logic [1:0]    op = 2'b00;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [BW-1:0] result;
    logic          busy;

    int errors = 0;
    int checks = 0;

    alu_iter_divider #(.BITWIDTH(BW)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .FLUSH     (FLUSH),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    always #5 CLK = ~CLK;

    // RISC-V M-extension semantics straight from the arithmetic definition.
    function automatic logic [BW-1:0] ref_model(input logic [BW-1:0] a, input logic [BW-1:0] b,
                                                input logic [1:0] o);
        int sa;
        int sb;
        sa = a;
        sb = b;
        if (b == 0) return o[1] ? a : 32'hFFFF_FFFF;
        if (!o[0]) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[1] ? 32'h0 : a;
            return o[1] ? 32'(sa % sb) : 32'(sa / sb);
        end
        return o[1] ? (a % b) : (a / b);
    endfunction

    // Issue one op (assumes in_ready) and wait for out_valid.
    // lat = cycle index of first out_valid, with the accept in cycle 0.
    task automatic run_op(input logic [BW-1:0] a, input logic [BW-1:0] b, input logic [1:0] o,
                          output logic [BW-1:0] res, output int lat);
        @(negedge CLK);
        op_a = a; op_b = b; op = o; in_valid = 1'b1;
        @(negedge CLK);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(negedge CLK);
            lat++;
        end
        res = result;
    endtask

    task automatic consume;
        out_ready = 1'b1;
        @(negedge CLK);
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || result !== '0) begin
            errors++;
            $display("FAIL reset_state: out_valid=%b busy=%b result=%h required 0/0/0", out_valid, busy, result);
        end
        RST = 1'b0;
        @(negedge CLK);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b required 1", in_ready);
        end
    endtask

    task automatic test_directed;
        logic [BW-1:0] va [5] = '{32'd100, 32'd100, 32'hFFFF_FFEC, 32'hFFFF_FFEC, 32'd20};
        logic [BW-1:0] vb [5] = '{32'd7, 32'd7, 32'd3, 32'd3, 32'hFFFF_FFFD};
        logic [1:0]    vo [5] = '{2'b01, 2'b11, 2'b00, 2'b10, 2'b10};
        logic [BW-1:0] ve [5] = '{32'd14, 32'd2, 32'hFFFF_FFFA, 32'hFFFF_FFFE, 32'd2};
        logic [BW-1:0] res;
        int lat;
        for (int i = 0; i < 5; i++) begin
            run_op(va[i], vb[i], vo[i], res, lat);
            checks++;
            if (res !== ve[i]) begin
                errors++;
                $display("FAIL directed_result[%0d]: got %h required %h", i, res, ve[i]);
            end
            checks++;
            if (lat != 34) begin
                errors++;
                $display("FAIL directed_latency[%0d]: got %0d required 34", i, lat);
            end
            consume();
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL directed_handshake[%0d]: out_valid=%b in_ready=%b required 0/1", i, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_special;
        logic [BW-1:0] va [4] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
        logic [BW-1:0] vb [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [1:0]    vo [4] = '{2'b01, 2'b10, 2'b00, 2'b10};
        logic [BW-1:0] ve [4] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'h0};
        logic [BW-1:0] res;
        int lat;
        for (int i = 0; i < 4; i++) begin
            run_op(va[i], vb[i], vo[i], res, lat);
            checks++;
            if (res !== ve[i] || lat != 2) begin
                errors++;
                $display("FAIL special[%0d]: got %h lat %0d required %h lat 2", i, res, lat, ve[i]);
            end
            consume();
        end
    endtask

    task automatic test_backpressure;
        logic [BW-1:0] res;
        int lat;
        run_op(32'd1000, 32'd10, 2'b01, res, lat);
        checks++;
        if (res !== 32'd100) begin
            errors++;
            $display("FAIL bp_result: got %h required %h", res, 32'd100);
        end
        for (int i = 0; i < 10; i++) begin
            op_a = $urandom; op_b = 32'd3; op = 2'b01; in_valid = 1'b1;
            @(negedge CLK);
            checks++;
            if (out_valid !== 1'b1 || result !== 32'd100 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold[%0d]: out_valid=%b result=%h in_ready=%b required 1/%h/0",
                         i, out_valid, result, in_ready, 32'd100);
            end
        end
        in_valid = 1'b0;
        consume();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: out_valid=%b in_ready=%b busy=%b required 0/1/0", out_valid, in_ready, busy);
        end
    endtask

    task automatic test_back_to_back;
        logic [BW-1:0] res;
        int lat;
        run_op(32'd77, 32'd5, 2'b01, res, lat);
        // Offer a new op in the very cycle the result is consumed.
        op_a = 32'd200; op_b = 32'd9; op = 2'b01; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge CLK);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_no_turnaround: out_valid=%b busy=%b required 0/0", out_valid, busy);
        end
        @(negedge CLK);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(negedge CLK);
            lat++;
        end
        checks++;
        if (result !== 32'd22 || lat != 34) begin
            errors++;
            $display("FAIL b2b_second: got %h lat %0d required %h lat 34", result, lat, 32'd22);
        end
        consume();
    endtask

    task automatic test_abort;
        logic [BW-1:0] res;
        int lat;
        int seen;
        // RST during CALC step 10
        @(negedge CLK);
        op_a = 32'h1234_5678; op_b = 32'd3; op = 2'b01; in_valid = 1'b1;
        @(negedge CLK);
        in_valid = 1'b0;
        repeat (9) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || result !== '0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_rst: busy=%b out_valid=%b result=%h in_ready=%b required 0/0/0/1",
                     busy, out_valid, result, in_ready);
        end
        seen = 0;
        repeat (40) begin
            @(negedge CLK);
            if (out_valid) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL abort_rst_quiet: out_valid cycles %0d required 0", seen);
        end
        // FLUSH during CALC step 20
        op_a = 32'h7654_3210; op_b = 32'd7; op = 2'b00; in_valid = 1'b1;
        @(negedge CLK);
        in_valid = 1'b0;
        repeat (19) @(negedge CLK);
        FLUSH = 1'b1;
        @(negedge CLK);
        FLUSH = 1'b0;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || result !== '0) begin
            errors++;
            $display("FAIL abort_flush: busy=%b out_valid=%b result=%h required 0/0/0", busy, out_valid, result);
        end
        seen = 0;
        repeat (40) begin
            @(negedge CLK);
            if (out_valid) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL abort_flush_quiet: out_valid cycles %0d required 0", seen);
        end
        // FLUSH with in_valid in IDLE must not accept
        op_a = 32'd9; op_b = 32'd0; op = 2'b01; in_valid = 1'b1; FLUSH = 1'b1;
        @(negedge CLK);
        in_valid = 1'b0; FLUSH = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL flush_idle_accept: busy=%b required 0", busy);
        end
        run_op(32'hFFFF_FFFF, 32'h10, 2'b01, res, lat);
        checks++;
        if (res !== 32'h0FFF_FFFF || lat != 34) begin
            errors++;
            $display("FAIL abort_recover: got %h lat %0d required %h lat 34", res, lat, 32'h0FFF_FFFF);
        end
        consume();
    endtask

    task automatic test_random;
        logic [BW-1:0] a, b, res, exp_res;
        logic [1:0]    o;
        int lat, exp_lat, sel;
        for (int i = 0; i < 40; i++) begin
            o   = 2'($urandom_range(0, 3));
            a   = $urandom;
            sel = $urandom_range(0, 7);
            case (sel)
                0: b = '0;
                1: begin b = '1; a = 32'h8000_0000; end
                2: b = 32'($urandom_range(1, 15));
                3: b = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
                default: b = $urandom;
            endcase
            exp_res = ref_model(a, b, o);
            exp_lat = (b == 0 || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 2 : 34;
            run_op(a, b, o, res, lat);
            checks++;
            if (res !== exp_res || lat != exp_lat) begin
                errors++;
                $display("FAIL random[%0d] op=%0d a=%h b=%h: got %h lat %0d required %h lat %0d",
                         i, o, a, b, res, lat, exp_res, exp_lat);
            end
            consume();
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_special();
        test_backpressure();
        test_back_to_back();
        test_abort();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
